pwm_capture: RTL

//  Receive-side counterpart of pwm_generator: measures an incoming asynchronous PWM waveform.

---
 rtl/pwm_capture_pkg.sv | 15 +
 rtl/pwm_capture_sync_edge_detect.sv | 36 +++
 rtl/pwm_capture.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared widths, timeout default and FSM state encoding for the PWM capture path.
package pwm_capture_pkg;

  localparam int unsigned DEF_VALUE_W  = 10;
  localparam int unsigned DEF_TLSB_W   = 12;
  localparam int unsigned DEF_PERIOD_W = 11;
  localparam int unsigned DEF_TIMEOUT  = 2047;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_capture_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input plus registered rise/fall pulses.
module pwm_capture_sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  // Synchronise, keep one cycle of history and register single-cycle edge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in LSB units
// (1 LSB = t_lsb clocks), with saturation and a no-edge timeout.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned VALUE_W  = DEF_VALUE_W,
  parameter int unsigned TLSB_W   = DEF_TLSB_W,
  parameter int unsigned PERIOD_W = DEF_PERIOD_W,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  input  logic [TLSB_W-1:0]   t_lsb,
  output logic [VALUE_W-1:0]  pwm_value,
  output logic [PERIOD_W-1:0] period_value,
  output logic                value_valid,
  output logic                period_valid,
  output logic                timeout
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  logic rise;
  logic fall;
  logic any_edge;

  logic [TLSB_W-1:0]   t_lsb_q;
  logic [TLSB_W-1:0]   presc_q;
  logic [TLSB_W-1:0]   presc_d;
  logic [TLSB_W-1:0]   t_eff;
  logic                tick;

  logic [VALUE_W-1:0]  hi_q;
  logic [VALUE_W-1:0]  hi_d;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] per_d;
  logic [IDLE_W-1:0]   idle_q;
  logic [IDLE_W-1:0]   idle_d;
  logic                to_fire;

  pwm_state_e          state_q;

  pwm_capture_sync_edge_detect u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (pwm_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign any_edge = rise | fall;

  // A programmed t_lsb of zero behaves as one clock per LSB.
  assign t_eff   = (t_lsb_q == '0) ? TLSB_W'(1) : t_lsb_q;
  assign tick    = (presc_q >= (t_eff - TLSB_W'(1)));
  assign presc_d = tick ? '0 : presc_q + TLSB_W'(1);

  // Saturating tick-driven increments; the FSM picks which ones to commit.
  assign hi_d   = (tick && (hi_q != '1))   ? hi_q + VALUE_W'(1)   : hi_q;
  assign per_d  = (tick && (per_q != '1))  ? per_q + PERIOD_W'(1) : per_q;
  assign idle_d = (tick && (idle_q != '1)) ? idle_q + IDLE_W'(1)  : idle_q;

  // An edge in the same cycle always wins over the timeout.
  assign to_fire = ~any_edge & ~timeout & (idle_d >= IDLE_W'(TIMEOUT));

  // Prescaler restarts and t_lsb is captured on every detected rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_lsb_q <= '0;
      presc_q <= '0;
    end else if (rise) begin
      t_lsb_q <= t_lsb;
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Idle counter: counts LSB ticks since the last edge of either polarity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else if (any_edge) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  // Measurement FSM with counters and registered result/valid outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hi_q         <= '0;
      per_q        <= '0;
      pwm_value    <= '0;
      period_value <= '0;
      value_valid  <= 1'b0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      value_valid  <= 1'b0;
      period_valid <= 1'b0;
      if (to_fire) begin
        timeout     <= 1'b1;
        state_q     <= ST_IDLE;
        pwm_value   <= (state_q == ST_HIGH) ? '1 : '0;
        value_valid <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise) begin
              state_q <= ST_HIGH;
              hi_q    <= '0;
              per_q   <= '0;
              timeout <= 1'b0;
            end
          end
          ST_HIGH: begin
            hi_q  <= hi_d;
            per_q <= per_d;
            if (fall) begin
              state_q     <= ST_LOW;
              pwm_value   <= hi_d;
              value_valid <= 1'b1;
            end
          end
          ST_LOW: begin
            per_q <= per_d;
            if (rise) begin
              state_q      <= ST_HIGH;
              period_value <= per_d;
              period_valid <= 1'b1;
              hi_q         <= '0;
              per_q        <= '0;
              timeout      <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
